// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline and pipe_hazard_ctrl.
// master: pipeline side. It drives the hazard inputs and receives the controls.
// slave : the controller. It receives the hazard inputs and drives the controls
//         and the performance counters.
// Signals:
//   ifid_rs_i/ifid_rt_i/ifid_uses_rt_i : source fields of the IF/ID instruction
//   idex_memread_i/idex_rt_i           : load in ID/EX and its destination
//   branch_taken_i, mem_stall_i        : branch resolution and data-memory busy
//   pc_write_o, ifid_hazard_o, ifid_flush_o, idex_bubble_o, halt_o : controls
//   stall_cnt_o, flush_cnt_o, timeout_o                            : status
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             ifid_uses_rt_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic             branch_taken_i;
    logic             mem_stall_i;
    logic             pc_write_o;
    logic             ifid_hazard_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             halt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             timeout_o;

    modport master (
        output ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, mem_stall_i,
        input  pc_write_o, ifid_hazard_o, ifid_flush_o, idex_bubble_o, halt_o,
               stall_cnt_o, flush_cnt_o, timeout_o
    );

    modport slave (
        input  ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, mem_stall_i,
        output pc_write_o, ifid_hazard_o, ifid_flush_o, idex_bubble_o, halt_o,
               stall_cnt_o, flush_cnt_o, timeout_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// The sequencer handles three events in this priority order:
//   1. Data-memory stall: the whole pipeline freezes.
//   2. Load-use hazard: IF/ID and the PC hold for one cycle, and a bubble goes into ID/EX.
//   3. Taken-branch flush: IF/ID is cleared.
// A branch that resolves during a freeze is remembered and flushes on release.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous reset, active high. It forces all controls low.
//   hz    : hazard bundle, slave side. See pipe_hazard_ctrl_if.
// The controls are combinational from state and inputs. The saturating
// counters and the sticky watchdog flag are registered.
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int LIMIT_W     = 8,
    parameter int STALL_LIMIT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pipe_hazard_ctrl_if.slave   hz
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t             state;
    logic               pend_flush;
    logic [LIMIT_W-1:0] wd_cnt;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;
    logic               timeout;

    logic load_use;
    logic flush_req;
    logic pc_write, hazard, flush, bubble, halt;

    // A load to r0 never creates a hazard. The rt field only matters when
    // the IF/ID instruction actually reads it.
    assign load_use = hz.idex_memread_i && (hz.idex_rt_i != 5'd0) &&
                      ((hz.idex_rt_i == hz.ifid_rs_i) ||
                       (hz.ifid_uses_rt_i && (hz.idex_rt_i == hz.ifid_rt_i)));

    assign flush_req = hz.branch_taken_i || pend_flush;

    always_comb begin
        pc_write = 1'b0;
        hazard   = 1'b0;
        flush    = 1'b0;
        bubble   = 1'b0;
        halt     = 1'b0;
        if (!rst_i) begin
            if (hz.mem_stall_i) begin
                halt     = 1'b1;
            end else if (load_use) begin
                hazard   = 1'b1;
                bubble   = 1'b1;
            end else if (flush_req) begin
                flush    = 1'b1;
                pc_write = 1'b1;
            end else begin
                pc_write = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= RUN;
            pend_flush <= 1'b0;
            wd_cnt     <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            timeout    <= 1'b0;
        end else begin
            if (hz.mem_stall_i) begin
                state <= MEM_WAIT;
                // On entry from RUN, the watchdog restarts at one stalled cycle.
                if (state == RUN)
                    wd_cnt <= LIMIT_W'(1);
                else if (wd_cnt != {LIMIT_W{1'b1}})
                    wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == LIMIT_W'(STALL_LIMIT - 1))
                    timeout <= 1'b1;
                // The branch pulse is not held by its source during a freeze,
                // so it is latched here.
                if (hz.branch_taken_i)
                    pend_flush <= 1'b1;
            end else begin
                state  <= RUN;
                wd_cnt <= '0;
                // A load-use stall keeps the pending flush for the next cycle.
                if (!load_use && flush_req)
                    pend_flush <= 1'b0;
            end

            if (!pc_write && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.pc_write_o    = pc_write;
    assign hz.ifid_hazard_o = hazard;
    assign hz.ifid_flush_o  = flush;
    assign hz.idex_bubble_o = bubble;
    assign hz.halt_o        = halt;
    assign hz.stall_cnt_o   = stall_cnt;
    assign hz.flush_cnt_o   = flush_cnt;
    assign hz.timeout_o     = timeout;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the PC write enable and the IF/ID hazard (hold), flush and halt controls. Also drives the ID/EX bubble insert.
- Arbitrates between three events: data-memory stall (global freeze), load-use hazard (1-cycle hold plus bubble) and taken-branch flush.
- Keeps saturating performance counters and a stall watchdog.

Parameters:
- CNT_W, 16: width of the stall and flush performance counters.
- LIMIT_W, 8: width of the consecutive-stall watchdog counter.
- STALL_LIMIT, 255: number of consecutive MEM_WAIT cycles that sets timeout_o. Must be less than 2^LIMIT_W.

Ports:
- clk_i, input, 1: clock; all state updates on posedge.
- rst_i, input, 1: synchronous active-high reset.
- ifid_rs_i, input, 5: rs field of the instruction in IF/ID.
- ifid_rt_i, input, 5: rt field of the instruction in IF/ID.
- ifid_uses_rt_i, input, 1: the IF/ID instruction reads rt.
- idex_memread_i, input, 1: the ID/EX instruction is a load.
- idex_rt_i, input, 5: destination register of the load in ID/EX.
- branch_taken_i, input, 1: single-cycle pulse; branch resolved taken. It is not held during a freeze.
- mem_stall_i, input, 1: data memory busy; the pipeline must freeze.
- pc_write_o, output, 1: PC update enable.
- ifid_hazard_o, output, 1: IF/ID hold.
- ifid_flush_o, output, 1: IF/ID clear.
- idex_bubble_o, output, 1: zero the control bits into ID/EX.
- halt_o, output, 1: freeze all pipeline registers.
- stall_cnt_o, output, CNT_W: cycles with pc_write_o=0.
- flush_cnt_o, output, CNT_W: cycles with ifid_flush_o=1.
- timeout_o, output, 1: sticky watchdog flag.

Behaviour:
- Reset is synchronous and active-high.
- Registered state: fsm (RUN, MEM_WAIT), pend_flush, wd_cnt (LIMIT_W bits), stall_cnt, flush_cnt, timeout.
- Effect of rst_i=1 at a posedge: fsm=RUN; pend_flush, wd_cnt, stall_cnt_o, flush_cnt_o and timeout_o all =0.
- While rst_i=1, all control outputs are forced to 0 combinationally, including pc_write_o=0.
- Control outputs are combinational from state and inputs, with 0-cycle latency. Counters update at the posedge after the event.
- load_use = idex_memread_i & (idex_rt_i!=0) & ((idex_rt_i==ifid_rs_i) | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)).
- Priority per cycle: mem_stall_i > load_use > flush (branch_taken_i | pend_flush) > normal.
- mem_stall_i=1, in any state:
  - Outputs: halt_o=1, pc_write_o=0; ifid_hazard_o, ifid_flush_o and idex_bubble_o =0.
  - Next fsm=MEM_WAIT.
  - If branch_taken_i=1 in this cycle, set pend_flush.
- mem_stall_i=0 with load_use:
  - Outputs: pc_write_o=0, ifid_hazard_o=1, idex_bubble_o=1, halt_o=0.
  - Any branch_taken_i in this cycle is ignored; the branch re-resolves next cycle.
  - pend_flush is retained.
  - Next fsm=RUN.
- mem_stall_i=0, no load_use, (branch_taken_i | pend_flush):
  - Outputs: ifid_flush_o=1, pc_write_o=1.
  - Clear pend_flush; next fsm=RUN.
- Otherwise: pc_write_o=1, all other control outputs =0, next fsm=RUN.
- MEM_WAIT exit: the first cycle with mem_stall_i=0 is evaluated by the rules above, so a pending flush issues in that same cycle.
- Watchdog:
  - wd_cnt increments each cycle with mem_stall_i=1, saturating at all-ones, and clears when mem_stall_i=0.
  - When wd_cnt==STALL_LIMIT-1 and mem_stall_i=1, timeout_o becomes 1 at the next edge and stays 1 until reset.
  - The watchdog has no effect on the halt behaviour.
- Counters:
  - stall_cnt_o += 1 each non-reset cycle with pc_write_o=0.
  - flush_cnt_o += 1 each cycle with ifid_flush_o=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Reset in MEM_WAIT: pend_flush is discarded and there is no flush after reset.

Test Plan:
- Reset then idle:
  - Stimulus: rst_i=1 for 2 cycles, then all inputs 0 for 5 cycles.
  - Required: during reset all control outputs =0. After reset pc_write_o=1, counters=0, timeout_o=0.
- Load-use:
  - Stimulus: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 for 1 cycle.
  - Required: pc_write_o=0, ifid_hazard_o=1, idex_bubble_o=1, and stall_cnt_o=1 afterwards.
  - Repeat with idex_rt_i=0: no stall.
  - Repeat with a rt match and ifid_uses_rt_i=0: no stall.
- Branch flush:
  - Stimulus: branch_taken_i pulse with no hazard.
  - Required: ifid_flush_o=1 and pc_write_o=1 in that cycle; flush_cnt_o=1.
  - Same pulse together with load_use: no flush; stall outputs only.
- Branch during freeze:
  - Stimulus: mem_stall_i=1 for 4 cycles, with branch_taken_i pulsed in cycle 1.
  - Required: halt_o=1 for 4 cycles, then ifid_flush_o=1 in the first cycle after release, then 0.
  - stall_cnt_o=4, flush_cnt_o=1.
- Watchdog:
  - Stimulus: STALL_LIMIT=4, mem_stall_i held for 6 cycles.
  - Required: timeout_o rises after the 4th stall cycle and stays 1 after release, until rst_i.
- Reset mid-stall and counter saturation:
  - Stimulus: assert rst_i during a MEM_WAIT with pend_flush set.
  - Required: no flush after reset.
  - With CNT_W=2, 5 stall cycles: stall_cnt_o holds at 3.
